// File: rtl/down_counter_pkg.sv
// Shared types and constants for the loadable countdown timer.
package down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 12;

endpackage

// File: rtl/down_counter.sv
// Loadable countdown timer with a one-cycle done pulse at terminal count.
// Optional build macro DOWN_COUNTER_AUTO_RELOAD_EN: terminal count reloads the
// last loaded value and keeps running, giving a periodic done pulse.
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | no countdown; count holds (normally 0), enable ignored
// RUN   | counting down one per enabled edge
// HOLD  | countdown paused by enable=0, count held
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             zero,
    output logic             done
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count_next;
    logic             done_next;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_next;
`endif

    // State, count, done (and reload) registers with async active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            done   <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload <= '0;
`endif
        end else begin
            state  <= state_next;
            count  <= count_next;
            done   <= done_next;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload <= reload_next;
`endif
        end
    end

    // Next-state: load beats decrement; a load abandons any countdown silently.
    always_comb begin
        state_next = state;
        count_next = count;
        done_next  = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        reload_next = reload;
`endif
        if (load) begin
            count_next = load_value;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_next = load_value;
`endif
            if (load_value == '0) begin
                state_next = IDLE;
                done_next  = 1'b1;
            end else begin
                state_next = RUN;
            end
        end else begin
            case (state)
                IDLE: state_next = IDLE;
                RUN, HOLD: begin
                    if (!enable) begin
                        state_next = HOLD;
                    end else if (count == WIDTH'(1)) begin
                        done_next = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                        count_next = reload;
                        state_next = RUN;
`else
                        count_next = '0;
                        state_next = IDLE;
`endif
                    end else if (count == '0) begin
                        // Never decrement through zero; drop back to idle.
                        state_next = IDLE;
                    end else begin
                        count_next = count - WIDTH'(1);
                        state_next = RUN;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Status outputs decoded from the registered state and count.
    always_comb begin
        busy = (state == RUN) || (state == HOLD);
        zero = (count == '0);
    end

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter (WIDTH = 12).
// Auto-reload checks are compiled in when DOWN_COUNTER_AUTO_RELOAD_EN is defined.
module tb_down_counter;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] load_value;
    logic         enable;
    logic [W-1:0] count;
    logic         busy;
    logic         zero;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    down_counter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .enable     (enable),
        .count      (count),
        .busy       (busy),
        .zero       (zero),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("comparison %s did not match", tag);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int b, input int d);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".done"},  32'(done),  32'(d));
        chk({tag, ".zero"},  32'(zero),  32'(c == 0));
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; load_value = '0; enable = 1'b0;
        #2;
        chk_all("reset", 0, 0, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk_all("post_reset", 0, 0, 0);

        // 1: async reset mid-countdown at 0x05A
        load = 1'b1; load_value = 12'h05C; enable = 1'b1;
        tick();
        load = 1'b0;
        chk_all("t1_load", 12'h05C, 1, 0);
        tick();
        tick();
        chk_all("t1_at5a", 12'h05A, 1, 0);
        #2 reset = 1'b0;
        #1;
        chk_all("t1_async", 0, 0, 0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("t1_idle", 0, 0, 0);
        end

        // 2: load 10, count down to terminal
        load = 1'b1; load_value = 12'd10; enable = 1'b1;
        tick();
        load = 1'b0;
        chk_all("t2_load", 10, 1, 0);
        for (int i = 9; i >= 1; i--) begin
            tick();
            chk_all("t2_run", i, 1, 0);
        end
        tick();
        chk_all("t2_done", 0, 0, 1);
        tick();
        chk_all("t2_after", 0, 0, 0);

        // 3: pause in HOLD and resume
        load = 1'b1; load_value = 12'd8; enable = 1'b0;
        tick();
        load = 1'b0;
        chk_all("t3_load", 8, 1, 0);
        enable = 1'b1;
        tick(); tick(); tick();
        chk_all("t3_run3", 5, 1, 0);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("t3_hold", 5, 1, 0);
        end
        enable = 1'b1;
        for (int i = 4; i >= 1; i--) begin
            tick();
            chk_all("t3_resume", i, 1, 0);
        end
        tick();
        chk_all("t3_done", 0, 0, 1);

        // 4: reload mid-count, load of zero, enable ignored in IDLE
        load = 1'b1; load_value = 12'd5; enable = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick();
        chk_all("t4_at3", 3, 1, 0);
        load = 1'b1; load_value = 12'hFFF;
        tick();
        chk_all("t4_fff", 12'hFFF, 1, 0);
        load_value = 12'd0;
        tick();
        load = 1'b0;
        chk_all("t4_load0", 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_all("t4_idle", 0, 0, 0);
        end

        // 5: load coincides with terminal decrement
        load = 1'b1; load_value = 12'd2; enable = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk_all("t5_at1", 1, 1, 0);
        load = 1'b1; load_value = 12'd7;
        tick();
        load = 1'b0;
        chk_all("t5_load_wins", 7, 1, 0);
        tick();
        chk_all("t5_run", 6, 1, 0);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        // 6: periodic auto-reload
        load = 1'b1; load_value = 12'd3; enable = 1'b1;
        tick();
        load = 1'b0;
        chk_all("t6_load", 3, 1, 0);
        for (int p = 0; p < 3; p++) begin
            tick();
            chk_all("t6_c2", 2, 1, 0);
            tick();
            chk_all("t6_c1", 1, 1, 0);
            tick();
            chk_all("t6_reload", 3, 1, 1);
        end
        load = 1'b1; load_value = 12'd0;
        tick();
        load = 1'b0;
        chk_all("t6_stop", 0, 0, 1);
        tick();
        chk_all("t6_idle", 0, 0, 0);
`else
        // Without auto-reload the run from test 5 finishes at zero in IDLE.
        for (int i = 5; i >= 1; i--) begin
            tick();
            chk_all("t5_tail", i, 1, 0);
        end
        tick();
        chk_all("t5_done", 0, 0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
Loadable countdown timer, the counterpart to the team's 12-bit up counter. It loads a start value, decrements by one per enabled clock, and signals terminal count with a one-cycle done pulse. It is used as the timeout/interval source for the lab datapath alongside up_counter, and shares its clk/reset/enable control style.

Parameters:
WIDTH, 12, counter width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; asserted when 0
load  input  1  capture load_value this edge; highest priority after reset
load_value  input  WIDTH  start value for the countdown
enable  input  1  decrement permission; 0 pauses the count
count  output  WIDTH  current counter value, registered
busy  output  1  1 while a countdown is in progress (RUN or HOLD)
zero  output  1  combinational (count == 0)
done  output  1  registered one-cycle pulse at terminal count

Behaviour:
- Reset (reset=0): takes effect immediately, independent of clk. Sets count=0, busy=0, done=0, state=IDLE. Deassertion is sampled at the next rising edge, and the first action can occur on that edge.
- States (2-bit):
  - IDLE: count holds, no wrap; enable is ignored; count stays at its value, normally 0.
  - RUN: counting down.
  - HOLD: paused mid-count.
  - There is no separate DONE state; done is a registered flag.
- done defaults to 0 every cycle unless set by a terminal event below.
- Priority per edge: reset > load > decrement.
- load=1 in any state:
  - count <= load_value next edge.
  - If load_value != 0: state goes to RUN. Any in-flight countdown is abandoned with no done pulse.
  - If load_value == 0: count <= 0, done <= 1, state goes to IDLE (immediate expiry).
- RUN with enable=1: count <= count-1. On the edge where count goes 1->0, done <= 1 and state goes to IDLE.
- RUN with enable=0: state goes to HOLD and count is held. HOLD with enable=1 returns to RUN and decrements on that same edge. Enable toggling per cycle is legal.
- Latency: with enable held high, done is 1 in the cycle after the Nth edge following the load edge. count shows N after the load edge, then N-1 ... 0.
- busy = (state==RUN || state==HOLD), registered via state. It is 0 in the cycle done=1.
- Underflow is impossible: a decrement is never applied at count==0.
- Arithmetic is unsigned WIDTH-bit only. No carry or borrow output.
- Simultaneous load and terminal decrement: load wins, done stays 0.

Optional Feature:
DOWN_COUNTER_AUTO_RELOAD_EN.
- When defined:
  - A WIDTH-bit reload register captures load_value on every load.
  - At terminal, instead of 1->0 the count goes 1->reload value, done pulses, and the state stays RUN. The result is a periodic pulse with period = reload value in enabled cycles.
  - load of 0 behaves as in base mode and stops the counter in IDLE.
- When undefined: no reload register; the counter stops at 0 in IDLE as described above.

Decomposition:
- Package down_counter_pkg holds:
  - a state typedef enum with values IDLE=2'd0, RUN=2'd1, HOLD=2'd2
  - the constant DEFAULT_WIDTH=12
- No sub-module. State, counter and done live in one sequential block plus a small next-state block.

Test Plan:
1. Run countdown, reset=0 asynchronously at count=0x05A between edges -> count=0, busy=0, done=0 before the next edge; after release, IDLE holds at 0.
2. load_value=10, load for 1 cycle, enable=1 -> count 10,9,...,0; done=1 for exactly one cycle after the 10th post-load edge; busy falls in that same cycle.
3. load 8, enable=1 for 3 edges, then 0 for 5 edges -> count holds at 5 with busy=1, no done; enable=1 -> done after 5 more edges.
4. At count=3, load 0xFFF -> next count=0xFFF, no done pulse; load 0 -> count=0, done pulses one cycle, busy stays 0; then enable=1 for 20 cycles in IDLE -> count stays 0, no done.
5. Simultaneous load=1 (value 7) and count=1 with enable=1 -> count=7, done=0, state RUN.
6. With DOWN_COUNTER_AUTO_RELOAD_EN, load 3, enable=1 -> count 3,2,1,3,2,1...; done pulses every 3 cycles, busy stays 1; load 0 -> stops with count=0, one done pulse.
